cfg_sender: RTL and testbench
=============================

CFG_SENDER -- requirements
Module: cfg_sender

Interface
REQ-001 Parameter CWIDTH, default 32: width of one configuration word.
REQ-002 Parameter DEPTH, default 4: command buffer depth in words; power of two, 2..16.
REQ-003 Parameter TIMEOUT, default 1024: busy-stall cycle limit; used only with CFG_SENDER_TIMEOUT_EN.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 push_valid  input  1  host offers a config word.
REQ-007 push_data  input  CWIDTH  host config word.
REQ-008 push_ready  output  1  buffer can accept a word this cycle.
REQ-009 level  output  $clog2(DEPTH)+1  words currently buffered.
REQ-010 cfg_valid  output  1  one-cycle issue pulse to the configured block.
REQ-011 cfg_data  output  CWIDTH  word being issued; meaningful only while cfg_valid=1.
REQ-012 cfg_busy  input  1  configured block cannot accept a word.
REQ-013 cfg_timeout  output  1  sticky stall flag; present only with CFG_SENDER_TIMEOUT_EN.

Function
REQ-014 push_ready SHALL be 1 exactly when level<DEPTH; it is combinational from level only.
REQ-015 A word SHALL be written when push_valid and push_ready are both 1 on a clock edge; otherwise push_data is ignored.
REQ-016 At level=DEPTH, push_ready SHALL be 0 even if a pop occurs in the same cycle; the host must retry.
REQ-017 Words SHALL be issued in FIFO order; read/write pointers wrap modulo DEPTH.
REQ-018 The FSM SHALL have states IDLE, SEND, GAP.
- IDLE: if level>0 and cfg_busy=0, go to SEND.
- SEND: lasts exactly 1 cycle, then go to GAP.
- GAP: lasts exactly 1 cycle, with cfg_busy ignored, then go to IDLE.
REQ-019 On the IDLE->SEND edge, the head word SHALL be loaded into the cfg_data register and popped, and cfg_valid is registered to 1.
REQ-020 cfg_valid SHALL be 1 only in SEND, giving a minimum spacing of 3 cycles between pulses.
REQ-021 Latency SHALL be: a word pushed at edge N into an empty buffer with cfg_busy=0 gives cfg_valid=1 during cycle N+1..N+2 (high after edge N+1).
REQ-022 cfg_data SHALL hold its last value outside SEND; it does not return to 0.
REQ-023 A simultaneous push and pop SHALL leave level unchanged, with both words handled correctly.
REQ-024 cfg_busy asserted during SEND or GAP SHALL NOT affect the current pulse; it is sampled in IDLE only.

Reset
REQ-025 While rst_n=0, the block SHALL hold: FSM=IDLE, pointers=0, level=0, cfg_valid=0, cfg_data=0, cfg_timeout=0; push_ready=1 as a consequence of level=0.
REQ-026 Reset asserted mid-SEND SHALL drop cfg_valid immediately and discard all buffered words.
REQ-027 Buffer storage SHALL need no reset.

Configuration
REQ-028 With macro CFG_SENDER_TIMEOUT_EN defined, a stall counter SHALL increment each cycle in IDLE with level>0 and cfg_busy=1, and clear otherwise.
REQ-029 When the stall counter reaches TIMEOUT, cfg_timeout SHALL set and stay set until reset; issuing continues normally and no words are dropped.
REQ-030 Without the macro, the counter SHALL be absent, the cfg_timeout port SHALL be absent, and the TIMEOUT parameter SHALL be unused.

Structure
REQ-031 A shared package cfg_pkg SHALL hold the FSM state enum (IDLE/SEND/GAP) and the default CWIDTH constant.
REQ-032 The buffer SHALL be one sub-module, cfg_fifo, providing pointers, level, push_ready and head data; the FSM, output registers and timeout counter stay in cfg_sender.

Verification
REQ-033 Single word: push 0xA5A5_0001 at cycle 0 with cfg_busy=0 -> one cfg_valid pulse at cycle 1 with cfg_data=0xA5A5_0001, then level=0.
REQ-034 Burst and full: push 5 words back-to-back with DEPTH=4 and cfg_busy=1 -> push_ready=0 after 4 accepts, 5th word rejected, no cfg_valid.
REQ-035 Release: from REQ-034, drop cfg_busy -> 4 pulses spaced exactly 3 cycles apart, data in push order.
REQ-036 Busy gating: raise cfg_busy in the cycle of a pulse while 2 words are buffered -> the current pulse completes; the next pulse waits until busy=0 is seen in IDLE.
REQ-037 Reset mid-SEND: assert rst_n=0 during a pulse with 3 words queued -> cfg_valid=0 immediately and level=0; after release, no pulse occurs without new pushes.
REQ-038 Timeout (macro on, TIMEOUT=8): hold cfg_busy=1 with 1 word queued -> cfg_timeout=1 after 8 stalled cycles; drop busy -> word issues and cfg_timeout stays 1.

Source files
------------

// File: rtl/cfg_pkg.sv
// Shared types for the config sender: issue FSM states and default word width.
package cfg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int CFG_CWIDTH = 32;

endpackage

// File: rtl/cfg_fifo.sv
// Command buffer for cfg_sender: DEPTH-word FIFO, head word visible combinationally.
// Write accepted when push_valid && push_ready; push_ready depends on level only, so a full buffer refuses even on a pop cycle.
module cfg_fifo #(
  parameter int CWIDTH = 32,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid,
  input  logic [CWIDTH-1:0] push_data,
  output logic              push_ready,
  input  logic              pop,
  output logic [CWIDTH-1:0] head_data,
  output logic [LW-1:0]     level
);

  logic [CWIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              w_push;

  assign push_ready = (r_level < LW'(DEPTH));
  assign w_push     = push_valid && push_ready;
  assign head_data  = r_mem[r_rd_ptr];
  assign level      = r_level;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Power-of-two DEPTH lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/cfg_sender.sv
// Config word sender: buffers host words and issues one-cycle cfg_valid pulses, min 3-cycle spacing, 1 cycle push-to-pulse.
// Issue waits while cfg_busy is seen in IDLE; optional sticky stall flag cfg_timeout under CFG_SENDER_TIMEOUT_EN.
module cfg_sender
  import cfg_pkg::*;
#(
  parameter int CWIDTH  = CFG_CWIDTH,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_valid,
  input  logic [CWIDTH-1:0]        push_data,
  output logic                     push_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     cfg_valid,
  output logic [CWIDTH-1:0]        cfg_data,
  input  logic                     cfg_busy
`ifdef CFG_SENDER_TIMEOUT_EN
  ,
  output logic                     cfg_timeout
`endif
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_pop;
  logic [CWIDTH-1:0] w_head_data;
  logic              r_cfg_valid;
  logic [CWIDTH-1:0] r_cfg_data;

  cfg_fifo #(
    .CWIDTH (CWIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .pop        (w_pop),
    .head_data  (w_head_data),
    .level      (level)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if ((level != '0) && !cfg_busy) begin
          w_state_nxt = SEND;
          w_pop       = 1'b1;
        end
      end
      SEND:    w_state_nxt = GAP;
      GAP:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // cfg_data is loaded only on the pop edge so it holds between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cfg_valid <= 1'b0;
      r_cfg_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cfg_valid <= w_pop;
      if (w_pop) begin
        r_cfg_data <= w_head_data;
      end
    end
  end

  assign cfg_valid = r_cfg_valid;
  assign cfg_data  = r_cfg_data;

`ifdef CFG_SENDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_stall_cnt;
  logic          r_timeout;
  logic          w_stall;

  assign w_stall = (r_state == IDLE) && (level != '0) && cfg_busy;

  // Counter saturates at TIMEOUT; the flag is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_timeout   <= 1'b0;
    end else begin
      if (!w_stall) begin
        r_stall_cnt <= '0;
      end else if (r_stall_cnt != TW'(TIMEOUT)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_stall && (r_stall_cnt == TW'(TIMEOUT - 1))) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign cfg_timeout = r_timeout;
`endif

endmodule

// File: tb/tb_cfg_sender.sv
// Directed self-checking bench for cfg_sender (DEPTH=4, CWIDTH=32); timeout case runs when CFG_SENDER_TIMEOUT_EN is defined.
module tb_cfg_sender;

  logic        clk;
  logic        rst_n;
  logic        push_valid;
  logic [31:0] push_data;
  logic        push_ready;
  logic [2:0]  level;
  logic        cfg_valid;
  logic [31:0] cfg_data;
  logic        cfg_busy;
`ifdef CFG_SENDER_TIMEOUT_EN
  logic        cfg_timeout;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  cfg_sender #(
    .CWIDTH  (32),
    .DEPTH   (4),
    .TIMEOUT (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .level      (level),
    .cfg_valid  (cfg_valid),
    .cfg_data   (cfg_data),
    .cfg_busy   (cfg_busy)
`ifdef CFG_SENDER_TIMEOUT_EN
    ,
    .cfg_timeout (cfg_timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] words [5];
    int          pulse_at [4];
    logic [31:0] pulse_dat [4];
    int          npulse;
    int          spurious;

    rst_n      = 1'b0;
    push_valid = 1'b0;
    push_data  = '0;
    cfg_busy   = 1'b0;
    #23;
    chk("rst_valid", {31'd0, cfg_valid}, 32'd0);
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_ready", {31'd0, push_ready}, 32'd1);
    chk("rst_data", cfg_data, 32'd0);
`ifdef CFG_SENDER_TIMEOUT_EN
    chk("rst_timeout", {31'd0, cfg_timeout}, 32'd0);
`endif
    rst_n = 1'b1;
    step();

    // Single word: pulse right after the edge following the push.
    push_valid = 1'b1;
    push_data  = 32'hA5A5_0001;
    step();
    push_valid = 1'b0;
    chk("single_lvl_after_push", {29'd0, level}, 32'd1);
    chk("single_no_pulse_yet", {31'd0, cfg_valid}, 32'd0);
    step();
    chk("single_pulse", {31'd0, cfg_valid}, 32'd1);
    chk("single_data", cfg_data, 32'hA5A5_0001);
    chk("single_lvl_empty", {29'd0, level}, 32'd0);
    step();
    chk("single_gap", {31'd0, cfg_valid}, 32'd0);
    chk("single_data_hold", cfg_data, 32'hA5A5_0001);
    step();
    chk("single_idle", {31'd0, cfg_valid}, 32'd0);

    // Burst into a busy target: 4 accepted, 5th refused.
    words[0] = 32'h1111_0000;
    words[1] = 32'h2222_0001;
    words[2] = 32'h3333_0002;
    words[3] = 32'h4444_0003;
    words[4] = 32'h5555_0004;
    cfg_busy = 1'b1;
    spurious = 0;
    for (int i = 0; i < 5; i++) begin
      push_valid = 1'b1;
      push_data  = words[i];
      chk($sformatf("burst_ready_%0d", i), {31'd0, push_ready}, (i < 4) ? 32'd1 : 32'd0);
      step();
      if (cfg_valid) spurious++;
    end
    push_valid = 1'b0;
    chk("burst_level_full", {29'd0, level}, 32'd4);
    chk("burst_ready_full", {31'd0, push_ready}, 32'd0);
    chk("burst_no_pulse", spurious, 32'd0);

    // Release: pulses on steps 1,4,7,10 carrying words 0..3.
    cfg_busy = 1'b0;
    npulse   = 0;
    for (int t = 1; t <= 14; t++) begin
      step();
      if (cfg_valid) begin
        if (npulse < 4) begin
          pulse_at[npulse]  = t;
          pulse_dat[npulse] = cfg_data;
        end
        npulse++;
      end
    end
    chk("release_count", npulse, 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("release_time_%0d", k), pulse_at[k], 1 + 3 * k);
      chk($sformatf("release_data_%0d", k), pulse_dat[k], words[k]);
    end
    chk("release_level", {29'd0, level}, 32'd0);
    chk("release_ready", {31'd0, push_ready}, 32'd1);

    // Busy gating, with a push and pop landing on the same edge.
    push_valid = 1'b1;
    push_data  = 32'hE000_0000;
    step();
    push_data  = 32'hE000_0001;
    step();
    push_valid = 1'b0;
    chk("gate_pulse0", {31'd0, cfg_valid}, 32'd1);
    chk("gate_data0", cfg_data, 32'hE000_0000);
    chk("gate_level_pushpop", {29'd0, level}, 32'd1);
    cfg_busy = 1'b1;
    spurious = 0;
    for (int t = 0; t < 6; t++) begin
      step();
      if (cfg_valid) spurious++;
    end
    chk("gate_held", spurious, 32'd0);
    chk("gate_level_held", {29'd0, level}, 32'd1);
    cfg_busy = 1'b0;
    step();
    chk("gate_pulse1", {31'd0, cfg_valid}, 32'd1);
    chk("gate_data1", cfg_data, 32'hE000_0001);
    step();
    step();

    // Reset in the middle of a pulse with 3 words still queued.
    cfg_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_valid = 1'b1;
      push_data  = 32'hF000_0000 + i;
      step();
    end
    push_valid = 1'b0;
    cfg_busy   = 1'b0;
    step();
    chk("rstmid_pulse", {31'd0, cfg_valid}, 32'd1);
    chk("rstmid_level_before", {29'd0, level}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid_drop", {31'd0, cfg_valid}, 32'd0);
    chk("rstmid_level_clear", {29'd0, level}, 32'd0);
    chk("rstmid_ready", {31'd0, push_ready}, 32'd1);
    step();
    rst_n    = 1'b1;
    spurious = 0;
    for (int t = 0; t < 8; t++) begin
      step();
      if (cfg_valid) spurious++;
    end
    chk("rstmid_no_pulse", spurious, 32'd0);
    chk("rstmid_level_after", {29'd0, level}, 32'd0);

`ifdef CFG_SENDER_TIMEOUT_EN
    // Stall counter: flag rises on the 8th stalled edge and stays set.
    cfg_busy   = 1'b1;
    push_valid = 1'b1;
    push_data  = 32'hC0DE_0008;
    step();
    push_valid = 1'b0;
    for (int t = 0; t < 7; t++) step();
    chk("tmo_before", {31'd0, cfg_timeout}, 32'd0);
    step();
    chk("tmo_set", {31'd0, cfg_timeout}, 32'd1);
    cfg_busy = 1'b0;
    step();
    chk("tmo_issue", {31'd0, cfg_valid}, 32'd1);
    chk("tmo_issue_data", cfg_data, 32'hC0DE_0008);
    chk("tmo_sticky", {31'd0, cfg_timeout}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
